quad_encoder_gen: RTL and testbench

- Parametrised quadrature-encoder signal generator, successor to the single-step A/B encoder block.
- Produces Gray-coded A/B phases, a once-per-revolution index Z, and a signed position count.
- Two motion sources:
  - continuous mode, driven by the horario/antihorario level inputs;
  - burst mode, which emits an exact number of steps via a valid/ready command handshake.
- Step rate comes from a programmable prescaler. Used as a stimulus source for motor/encoder interface blocks and their testbenches.

---
 rtl/quad_encoder_gen.sv | 212 +++++++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen
// Quadrature-encoder signal generator. Emits Gray-coded A/B phases, a
// once-per-revolution index Z and a signed position count. Motion comes
// either from the continuous direction levels (horario / antihorario) or
// from a burst command that emits an exact number of steps. The step rate
// is set by a prescaler that fires once every period_eff clock cycles.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   period            clock cycles per quadrature step (0 behaves as 1)
//   horario           continuous clockwise request (level)
//   antihorario       continuous counter-clockwise request (level)
//   cmd_valid/ready   burst command handshake (ready = state is IDLE)
//   cmd_dir           burst direction, 0 = clockwise, 1 = counter-clockwise
//   cmd_steps         number of quadrature steps in the burst
//   A, B              quadrature phases (registered)
//   Z                 index, high while the revolution counter is zero
//   position          signed step count, wraps modulo 2^POS_W
//   busy              high while continuous or burst motion is active
//   done              one-cycle pulse when a burst completes
module quad_encoder_gen #(
  parameter int DIV_W = 16,
  parameter int POS_W = 16,
  parameter int CNT_W = 16,
  parameter int CPR   = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] period,
  input  logic             horario,
  input  logic             antihorario,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam int REV_W = $clog2(CPR);
  localparam logic [REV_W-1:0] REV_LAST = REV_W'(CPR - 1);
  localparam logic [REV_W-1:0] REV_ZERO = {REV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1'b1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  // Next {A,B} for one quadrature step. Clockwise walks 00->10->11->01,
  // counter-clockwise walks the same ring backwards.
  function automatic logic [1:0] phase_next(input logic [1:0] ab, input logic ccw);
    logic [1:0] nx;
    if (ccw) begin
      nx = {ab[0], ~ab[1]};
    end else begin
      nx = {~ab[0], ab[1]};
    end
    return nx;
  endfunction

  logic [1:0]       state_r, state_nx_s;
  logic [DIV_W-1:0] period_eff_r, period_eff_nx_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_nx_s;
  logic [CNT_W-1:0] remaining_r, remaining_nx_s;
  logic             burst_dir_r, burst_dir_nx_s;
  logic             a_r, b_r, z_r, done_r;
  logic [POS_W-1:0] position_r;
  logic [REV_W-1:0] rev_cnt_r, rev_cnt_nx_s;
  logic [1:0]       ab_nx_s;
  logic [POS_W-1:0] position_nx_s;
  logic             z_nx_s, done_nx_s;
  logic             step_s, step_ccw_s;
  logic [DIV_W-1:0] period_in_eff_s;
  logic             tick_s;

  assign period_in_eff_s = (period == DIV_ZERO) ? DIV_ONE : period;
  assign tick_s          = (div_cnt_r == (period_eff_r - DIV_ONE));

  // Mode control: command acceptance, prescaler and burst bookkeeping.
  always_comb begin
    state_nx_s      = state_r;
    period_eff_nx_s = period_eff_r;
    div_cnt_nx_s    = div_cnt_r;
    remaining_nx_s  = remaining_r;
    burst_dir_nx_s  = burst_dir_r;
    done_nx_s       = 1'b0;
    step_s          = 1'b0;
    step_ccw_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          period_eff_nx_s = period_in_eff_s;
          burst_dir_nx_s  = cmd_dir;
          remaining_nx_s  = cmd_steps;
          div_cnt_nx_s    = DIV_ZERO;
          // A zero-length burst completes on the accept edge itself.
          if (cmd_steps == CNT_ZERO) begin
            done_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_BURST;
          end
        end else if (horario ^ antihorario) begin
          state_nx_s      = ST_CONT;
          period_eff_nx_s = period_in_eff_s;
          div_cnt_nx_s    = DIV_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CONT: begin
        // Conflicting or released inputs stop motion without a step.
        if (horario == antihorario) begin
          state_nx_s   = ST_IDLE;
          div_cnt_nx_s = DIV_ZERO;
        end else if (tick_s) begin
          step_s       = 1'b1;
          step_ccw_s   = antihorario;
          div_cnt_nx_s = DIV_ZERO;
        end else begin
          div_cnt_nx_s = div_cnt_r + DIV_ONE;
        end
      end
      ST_BURST: begin
        if (tick_s) begin
          step_s         = 1'b1;
          step_ccw_s     = burst_dir_r;
          div_cnt_nx_s   = DIV_ZERO;
          remaining_nx_s = remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            state_nx_s = ST_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_BURST;
          end
        end else begin
          div_cnt_nx_s = div_cnt_r + DIV_ONE;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        div_cnt_nx_s = DIV_ZERO;
      end
    endcase
  end

  // Step side effects: phase, position, revolution counter and index.
  always_comb begin
    ab_nx_s       = {a_r, b_r};
    position_nx_s = position_r;
    rev_cnt_nx_s  = rev_cnt_r;
    z_nx_s        = z_r;
    if (step_s) begin
      ab_nx_s = phase_next({a_r, b_r}, step_ccw_s);
      if (step_ccw_s) begin
        position_nx_s = position_r - POS_ONE;
        rev_cnt_nx_s  = (rev_cnt_r == REV_ZERO) ? REV_LAST : (rev_cnt_r - REV_W'(1'b1));
      end else begin
        position_nx_s = position_r + POS_ONE;
        rev_cnt_nx_s  = (rev_cnt_r == REV_LAST) ? REV_ZERO : (rev_cnt_r + REV_W'(1'b1));
      end
      z_nx_s = (rev_cnt_nx_s == REV_ZERO);
    end else begin
      z_nx_s = z_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      period_eff_r <= DIV_ONE;
      div_cnt_r    <= DIV_ZERO;
      remaining_r  <= CNT_ZERO;
      burst_dir_r  <= 1'b0;
      a_r          <= 1'b0;
      b_r          <= 1'b0;
      z_r          <= 1'b1;
      position_r   <= {POS_W{1'b0}};
      rev_cnt_r    <= REV_ZERO;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      period_eff_r <= period_eff_nx_s;
      div_cnt_r    <= div_cnt_nx_s;
      remaining_r  <= remaining_nx_s;
      burst_dir_r  <= burst_dir_nx_s;
      a_r          <= ab_nx_s[1];
      b_r          <= ab_nx_s[0];
      z_r          <= z_nx_s;
      position_r   <= position_nx_s;
      rev_cnt_r    <= rev_cnt_nx_s;
      done_r       <= done_nx_s;
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign A         = a_r;
  assign B         = b_r;
  assign Z         = z_r;
  assign position  = position_r;
  assign done      = done_r;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Testbench for quad_encoder_gen: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-level reference model.
module tb_quad_encoder_gen;

  localparam int CPR = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] period;
  logic        horario, antihorario;
  logic        cmd_valid, cmd_dir;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        A, B, Z, busy, done;
  logic [15:0] position;

  int checks = 0;
  int errors = 0;

  quad_encoder_gen #(.DIV_W(16), .POS_W(16), .CNT_W(16), .CPR(CPR)) dut (
    .clk(clk), .rst(rst), .period(period), .horario(horario),
    .antihorario(antihorario), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .A(A), .B(B), .Z(Z),
    .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 continuous, 2 burst.
  int m_mode, m_per, m_cnt, m_left, m_dir, m_pos, m_rev, m_ph, m_done;
  logic [1:0] ab_tab [4];

  task automatic model_reset();
    m_mode = 0; m_per = 1; m_cnt = 0; m_left = 0; m_dir = 0;
    m_pos = 0; m_rev = 0; m_ph = 0; m_done = 0;
  endtask

  task automatic do_step(input int d);
    m_pos = (((m_pos + d) % 65536) + 65536) % 65536;
    m_rev = (m_rev + d + CPR) % CPR;
    m_ph  = (m_ph + d + 4) % 4;
  endtask

  task automatic model_step();
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (cmd_valid) begin
        m_per = (period == 16'd0) ? 1 : int'(period);
        if (cmd_steps == 16'd0) m_done = 1;
        else begin
          m_mode = 2; m_left = int'(cmd_steps); m_dir = int'(cmd_dir); m_cnt = 0;
        end
      end else if (horario != antihorario) begin
        m_mode = 1; m_per = (period == 16'd0) ? 1 : int'(period); m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (horario == antihorario) m_mode = 0;
      else begin
        m_cnt++;
        if (m_cnt == m_per) begin
          m_cnt = 0;
          do_step(antihorario ? -1 : 1);
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt == m_per) begin
        m_cnt = 0;
        do_step((m_dir != 0) ? -1 : 1);
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic [1:0] ab_e;
    ab_e = ab_tab[m_ph];
    chk("AB", {30'd0, A, B}, {30'd0, ab_e});
    chk("Z", {31'd0, Z}, (m_rev == 0) ? 32'd1 : 32'd0);
    chk("position", {16'd0, position}, m_pos);
    chk("busy", {31'd0, busy}, (m_mode != 0) ? 32'd1 : 32'd0);
    chk("done", {31'd0, done}, m_done);
    chk("cmd_ready", {31'd0, cmd_ready}, (m_mode == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  task automatic idle_inputs();
    horario = 1'b0; antihorario = 1'b0; cmd_valid = 1'b0;
    cmd_dir = 1'b0; cmd_steps = 16'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask

  initial begin : stim
    int low_cnt;
    int done_cnt;
    ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;
    model_reset();
    rst = 1'b1; period = 16'd4; idle_inputs();

    // Reset state.
    cyc(2);
    chk("rst_AB", {30'd0, A, B}, 32'd0);
    chk("rst_Z", {31'd0, Z}, 32'd1);
    chk("rst_pos", {16'd0, position}, 32'd0);
    rst = 1'b0;

    // Continuous clockwise, period 4: entry edge plus 20 active edges.
    period = 16'd4; horario = 1'b1;
    cyc(4);
    chk("cw_hold_before_tick", {30'd0, A, B}, 32'd0);
    cyc(1);
    chk("cw_first_step", {30'd0, A, B}, 32'b10);
    cyc(16);
    chk("cw_pos5", {16'd0, position}, 32'd5);
    chk("cw_busy", {31'd0, busy}, 32'd1);
    horario = 1'b0; cyc(1);

    // Continuous counter-clockwise, period 0 steps every cycle.
    do_reset();
    period = 16'd0; antihorario = 1'b1;
    cyc(2);
    chk("ccw_pos_wrap", {16'd0, position}, 32'h0000FFFF);
    chk("ccw_Z_low", {31'd0, Z}, 32'd0);
    chk("ccw_AB", {30'd0, A, B}, 32'b01);
    cyc(3);
    antihorario = 1'b0; cyc(1);

    // Full-revolution burst.
    do_reset();
    period = 16'd1; cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd400;
    cyc(1);
    cmd_valid = 1'b0;
    low_cnt = (cmd_ready == 1'b0) ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (cmd_ready == 1'b0) low_cnt++;
      if (done == 1'b1) done_cnt++;
    end
    chk("rev_ready_low_cycles", low_cnt, 32'd400);
    chk("rev_Z", {31'd0, Z}, 32'd1);
    chk("rev_pos", {16'd0, position}, 32'd400);
    chk("rev_done", {31'd0, done}, 32'd1);
    chk("rev_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    chk("rev_done_single", done_cnt + ((done == 1'b1) ? 1 : 0), 32'd1);

    // Conflicting inputs from IDLE and mid-CONT.
    do_reset();
    period = 16'd1; horario = 1'b1; antihorario = 1'b1;
    cyc(3);
    chk("conflict_idle_pos", {16'd0, position}, 32'd0);
    antihorario = 1'b0; cyc(3);
    antihorario = 1'b1; cyc(2);
    chk("conflict_AB_hold", {30'd0, A, B}, 32'b11);
    chk("conflict_pos_hold", {16'd0, position}, 32'd2);
    chk("conflict_busy", {31'd0, busy}, 32'd0);
    idle_inputs(); cyc(1);

    // Zero-length burst, then burst taking priority over horario.
    cmd_valid = 1'b1; cmd_steps = 16'd0; cyc(1);
    cmd_valid = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_pos", {16'd0, position}, 32'd2);
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b1; period = 16'd2; horario = 1'b1;
    cyc(1);
    cmd_valid = 1'b0;
    cyc(6);
    chk("prio_done", {31'd0, done}, 32'd1);
    chk("prio_pos", {16'd0, position}, 32'hFFFF);
    idle_inputs(); cyc(2);

    // Reset mid-burst after 3 of 10 steps.
    period = 16'd1; cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = 1'b0;
    cyc(1);
    cmd_valid = 1'b0; cyc(3);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("abort_AB", {30'd0, A, B}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    cyc(2);
    chk("abort_no_done", {31'd0, done}, 32'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) horario = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) antihorario = $urandom_range(0, 1) != 0;
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_dir = $urandom_range(0, 1) != 0;
      cmd_steps = 16'($urandom_range(0, 5));
      period = 16'($urandom_range(0, 3));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
